// File: rtl/gray_codec_pipe_if.sv
// Handshake bundle for gray_codec_pipe: upstream word/mode stream in, converted stream out.
// The master side drives words and out_ready; the slave side is the codec itself.
interface gray_codec_pipe_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             out_err;
  logic [7:0]       err_cnt;

  modport master (
    output in, mode, in_valid, out_ready,
    input  in_ready, out, out_valid, out_err, err_cnt
  );

  modport slave (
    input  in, mode, in_valid, out_ready,
    output in_ready, out, out_valid, out_err, err_cnt
  );
endinterface

// File: rtl/gray_codec_pipe.sv
// Pipelined gray<->binary converter with per-word mode, gray-stream adjacency
// checking and a saturating error counter.
module gray_codec_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  gray_codec_pipe_if.slave bus
);
  localparam int LAST = STAGES - 1;

  logic             vld_q  [STAGES];
  logic             vld_d  [STAGES];
  logic             mode_q [STAGES];
  logic             mode_d [STAGES];
  logic             err_q  [STAGES];
  logic             err_d  [STAGES];
  logic [WIDTH-1:0] dat_q  [STAGES];
  logic [WIDTH-1:0] dat_d  [STAGES];

  logic [WIDTH-1:0] ref_q, ref_d;
  logic             ref_valid_q, ref_valid_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             advance;
  logic             accept;
  logic             transfer;
  logic             adj_err;
  logic [WIDTH-1:0] diff;

  // Raw words travel down the pipe; conversion happens on the final stage.
  function automatic logic [WIDTH-1:0] convert(input logic [WIDTH-1:0] v,
                                               input logic             to_gray);
    logic [WIDTH-1:0] r;
    r = '0;
    r[WIDTH-1] = v[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      r[i] = to_gray ? (v[i+1] ^ v[i]) : (r[i+1] ^ v[i]);
    end
    return r;
  endfunction

  always_comb begin
    advance  = !vld_q[LAST] || bus.out_ready;
    accept   = bus.in_valid && advance;
    transfer = vld_q[LAST] && bus.out_ready;
    diff     = bus.in ^ ref_q;
    // x & (x-1) is nonzero exactly when x has two or more bits set.
    adj_err  = !bus.mode && ref_valid_q && (|(diff & (diff - WIDTH'(1))));

    for (int i = 0; i < STAGES; i++) begin
      vld_d[i]  = vld_q[i];
      mode_d[i] = mode_q[i];
      err_d[i]  = err_q[i];
      dat_d[i]  = dat_q[i];
    end
    ref_d       = ref_q;
    ref_valid_d = ref_valid_q;
    err_cnt_d   = err_cnt_q;

    if (advance) begin
      vld_d[0]  = bus.in_valid;
      mode_d[0] = bus.mode;
      err_d[0]  = bus.in_valid && adj_err;
      dat_d[0]  = bus.in;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i]  = vld_q[i-1];
        mode_d[i] = mode_q[i-1];
        err_d[i]  = err_q[i-1];
        dat_d[i]  = dat_q[i-1];
      end
    end

    if (accept && !bus.mode) begin
      ref_d       = bus.in;
      ref_valid_d = 1'b1;
    end

    if (transfer && err_q[LAST] && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_q[i]  <= 1'b0;
        mode_q[i] <= 1'b0;
        err_q[i]  <= 1'b0;
        dat_q[i]  <= '0;
      end
      ref_q       <= '0;
      ref_valid_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        vld_q[i]  <= vld_d[i];
        mode_q[i] <= mode_d[i];
        err_q[i]  <= err_d[i];
        dat_q[i]  <= dat_d[i];
      end
      ref_q       <= ref_d;
      ref_valid_q <= ref_valid_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out       = convert(dat_q[LAST], mode_q[LAST]);
  assign bus.out_valid = vld_q[LAST];
  assign bus.out_err   = err_q[LAST];
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Bench for gray_codec_pipe: directed literal cases, randomized traffic against a
// transaction-level model, and 8-bit round trips at every pipeline depth.
module tb_gray_codec_pipe;
  localparam int W = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_codec_pipe_if #(.WIDTH(W)) bus ();
  gray_codec_pipe #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  // 8-bit round-trip instances, one per legal depth, sharing one stimulus
  logic [7:0] rt_in    = '0;
  logic       rt_mode  = 1'b0;
  logic       rt_valid = 1'b0;
  logic [7:0] rt_out [4];
  logic       rt_ov  [4];

  for (genvar g = 0; g < 4; g++) begin : g_rt
    gray_codec_pipe_if #(.WIDTH(8)) rif ();
    assign rif.in        = rt_in;
    assign rif.mode      = rt_mode;
    assign rif.in_valid  = rt_valid;
    assign rif.out_ready = 1'b1;
    assign rt_out[g]     = rif.out;
    assign rt_ov[g]      = rif.out_valid;
    gray_codec_pipe #(.WIDTH(8), .STAGES(g + 1)) u_rt (.clk(clk), .rst(rst), .bus(rif));
  end

  logic [7:0] cap0[$];
  logic [7:0] cap1[$];
  logic [7:0] cap2[$];
  logic [7:0] cap3[$];

  initial forever begin
    @(negedge clk);
    if (rt_ov[0]) cap0.push_back(rt_out[0]);
    if (rt_ov[1]) cap1.push_back(rt_out[1]);
    if (rt_ov[2]) cap2.push_back(rt_out[2]);
    if (rt_ov[3]) cap3.push_back(rt_out[3]);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Transaction model: each word counts the pipeline advances it has seen
  // and is presented once it has seen S of them.
  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           adv;
  } item_t;

  item_t        mq[$];
  item_t        m_item;
  logic [W-1:0] m_ref;
  bit           m_ref_valid = 1'b0;
  int           m_cnt       = 0;
  bit           model_live  = 1'b0;
  bit           m_ev;
  bit           c_ev;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ref       = '0;
      m_ref_valid = 1'b0;
      m_cnt       = 0;
      model_live  = 1'b1;
    end else if (model_live) begin
      m_ev = (mq.size() > 0) && (mq[0].adv == S);
      if (!m_ev || bus.out_ready) begin
        if (m_ev) begin
          if (mq[0].err && m_cnt < 255) m_cnt++;
          void'(mq.pop_front());
        end
        foreach (mq[i]) mq[i].adv++;
        if (bus.in_valid) begin
          m_item.data = bus.mode ? b2g(bus.in) : g2b(bus.in);
          m_item.err  = !bus.mode && m_ref_valid && ($countones(bus.in ^ m_ref) > 1);
          m_item.adv  = 1;
          if (!bus.mode) begin
            m_ref       = bus.in;
            m_ref_valid = 1'b1;
          end
          mq.push_back(m_item);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (model_live && !rst) begin
      c_ev = (mq.size() > 0) && (mq[0].adv == S);
      checkOutput("out_valid", bus.out_valid, c_ev);
      checkOutput("in_ready", bus.in_ready, !c_ev || bus.out_ready);
      if (c_ev) begin
        checkOutput("out", bus.out, mq[0].data);
        checkOutput("out_err", bus.out_err, mq[0].err);
      end else begin
        checkOutput("out_err_idle", bus.out_err, 1'b0);
      end
      checkOutput("err_cnt", bus.err_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [W-1:0] d, input logic m, input logic v,
                               input logic ordy);
    bus.in        = d;
    bus.mode      = m;
    bus.in_valid  = v;
    bus.out_ready = ordy;
  endtask

  task automatic step(input logic [W-1:0] d, input logic m, input logic v, input logic ordy);
    tick();
    applyStimulus(d, m, v, ordy);
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge of the first cycle after reset is released.
  task automatic doReset();
    tick();
    rst = 1'b1;
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkCap(input string name, input logic [7:0] q[$], input bit to_gray);
    logic [7:0] v;
    checkOutput({name, "_count"}, q.size(), 256);
    for (int i = 0; i < 256 && i < q.size(); i++) begin
      v = 8'(i);
      checkOutput(name, q[i], to_gray ? (v ^ (v >> 1)) : v);
    end
  endtask

  initial begin
    logic [W-1:0] seq [4];
    logic [W-1:0] seq_out [4];
    logic         seq_err [4];
    logic [W-1:0] rnd_prev;
    logic [7:0]   g8;

    applyStimulus('0, 1'b0, 1'b0, 1'b1);

    // Single gray word: latency of exactly two cycles
    doReset();
    checkOutput("rst_in_ready", bus.in_ready, 1'b1);
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_err_cnt", bus.err_cnt, 8'd0);
    step(4'b1011, 1'b0, 1'b1, 1'b1);
    checkOutput("lat_in_ready", bus.in_ready, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1);
    checkOutput("lat_n1_valid", bus.out_valid, 1'b0);
    step('0, 1'b0, 1'b0, 1'b1);
    checkOutput("lat_n2_valid", bus.out_valid, 1'b1);
    checkOutput("lat_n2_out", bus.out, 4'b1101);
    checkOutput("lat_n2_err", bus.out_err, 1'b0);

    // Back-to-back mixed modes
    step(4'b1011, 1'b0, 1'b1, 1'b1);
    step(4'b1101, 1'b1, 1'b1, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1);
    checkOutput("mix_out0", bus.out, 4'b1101);
    checkOutput("mix_valid0", bus.out_valid, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1);
    checkOutput("mix_out1", bus.out, 4'b1011);
    checkOutput("mix_valid1", bus.out_valid, 1'b1);

    // Full pipe stalled for three cycles
    step(4'b0100, 1'b1, 1'b1, 1'b0);
    step(4'b0101, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step('0, 1'b0, 1'b0, 1'b0);
      checkOutput("stall_in_ready", bus.in_ready, 1'b0);
      checkOutput("stall_valid", bus.out_valid, 1'b1);
      checkOutput("stall_out", bus.out, 4'b0110);
    end
    step('0, 1'b0, 1'b0, 1'b1);
    checkOutput("release_out0", bus.out, 4'b0110);
    step('0, 1'b0, 1'b0, 1'b1);
    checkOutput("release_out1", bus.out, 4'b0111);
    checkOutput("release_valid1", bus.out_valid, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1);
    checkOutput("release_empty", bus.out_valid, 1'b0);

    // Adjacency sequence
    seq     = '{4'b0000, 4'b0001, 4'b0011, 4'b0110};
    seq_out = '{4'b0000, 4'b0001, 4'b0010, 4'b0100};
    seq_err = '{1'b0, 1'b0, 1'b0, 1'b1};
    doReset();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) step(seq[k], 1'b0, 1'b1, 1'b1);
      else       step('0, 1'b0, 1'b0, 1'b1);
      if (k >= 2) begin
        checkOutput("adj_out", bus.out, seq_out[k-2]);
        checkOutput("adj_err", bus.out_err, seq_err[k-2]);
      end
    end
    step('0, 1'b0, 1'b0, 1'b1);
    checkOutput("adj_err_cnt", bus.err_cnt, 8'd1);

    // Reset with two words in flight
    step(4'b0101, 1'b1, 1'b1, 1'b1);
    step(4'b1010, 1'b1, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", bus.out_valid, 1'b0);
    checkOutput("midrst_err_cnt", bus.err_cnt, 8'd0);
    checkOutput("midrst_in_ready", bus.in_ready, 1'b1);
    step(4'b1111, 1'b0, 1'b1, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1);
    checkOutput("midrst_out", bus.out, 4'b1010);
    checkOutput("midrst_err", bus.out_err, 1'b0);

    // 300 erroring transfers saturate the counter
    doReset();
    for (int i = 0; i < 301; i++) step((i % 2) ? 4'b1111 : 4'b0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step('0, 1'b0, 1'b0, 1'b1);
    checkOutput("sat_err_cnt", bus.err_cnt, 8'd255);

    // Randomized traffic with occasional resets
    doReset();
    rnd_prev = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        doReset();
      end else begin
        if ($urandom_range(1) == 0) rnd_prev = W'($urandom);
        else                        rnd_prev = rnd_prev ^ (W'(1) << $urandom_range(W - 1));
        step(rnd_prev, 1'($urandom_range(3) == 0), 1'($urandom_range(9) < 7),
             1'($urandom_range(3) != 0));
      end
    end
    for (int i = 0; i < 8; i++) step('0, 1'b0, 1'b0, 1'b1);
    checkOutput("drain_empty", bus.out_valid, 1'b0);

    // 8-bit round trips at depths 1..4
    cap0.delete(); cap1.delete(); cap2.delete(); cap3.delete();
    for (int v = 0; v < 256; v++) begin
      tick();
      rt_in = 8'(v); rt_mode = 1'b1; rt_valid = 1'b1;
      @(negedge clk);
    end
    tick();
    rt_valid = 1'b0;
    for (int i = 0; i < 8; i++) step('0, 1'b0, 1'b0, 1'b1);
    checkCap("rt_gray_s1", cap0, 1'b1);
    checkCap("rt_gray_s2", cap1, 1'b1);
    checkCap("rt_gray_s3", cap2, 1'b1);
    checkCap("rt_gray_s4", cap3, 1'b1);

    cap0.delete(); cap1.delete(); cap2.delete(); cap3.delete();
    for (int v = 0; v < 256; v++) begin
      tick();
      g8 = 8'(v);
      rt_in = g8 ^ (g8 >> 1); rt_mode = 1'b0; rt_valid = 1'b1;
      @(negedge clk);
    end
    tick();
    rt_valid = 1'b0;
    for (int i = 0; i < 8; i++) step('0, 1'b0, 1'b0, 1'b1);
    checkCap("rt_bin_s1", cap0, 1'b0);
    checkCap("rt_bin_s2", cap1, 1'b0);
    checkCap("rt_bin_s3", cap2, 1'b0);
    checkCap("rt_bin_s4", cap3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
